// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous frame-buffer RAM between the VGA
// scan-out reader and the game-logic pixel writer. Display reads always win
// the RAM. Writes are queued in a small FIFO and drained into any cycle
// without a display request, mostly during blanking.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   disp_req/disp_addr    : display read request for this cycle
//   disp_valid/disp_data  : read result, 3 cycles after disp_req
//   wr_valid/wr_ready     : writer handshake (wr_ready = FIFO not full)
//   wr_addr/wr_data       : write word offered by the writer
//   mem_en/mem_we         : registered RAM command (00 idle, 10 read, 11 write)
//   mem_addr/mem_wdata    : registered RAM address / write data
//   mem_rdata             : RAM read data, one cycle after the enable
//   fifo_level            : current write FIFO occupancy
//   stall_cnt             : saturating count of writes blocked by the display
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12,
    parameter int WR_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      disp_req,
    input  logic [ADDR_W-1:0]         disp_addr,
    output logic                      disp_valid,
    output logic [DATA_W-1:0]         disp_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [$clog2(WR_DEPTH):0] fifo_level,
    output logic [15:0]               stall_cnt
);

    localparam int PTR_W = $clog2(WR_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WR_DEPTH);

    // The command state is the {mem_en, mem_we} pair itself.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b10,
        ST_WR   = 2'b11
    } cmd_t;

    cmd_t              state;
    cmd_t              state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    logic [ENT_W-1:0]  fifo_mem [WR_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              rd_vld_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fifo_empty = (count == '0);
    assign wr_ready   = (count != FULL_CNT);
    assign push       = wr_valid && wr_ready;
    // A word pushed on this edge is not yet counted, so it cannot fall through.
    assign pop        = !disp_req && !fifo_empty;
    assign {head_addr, head_data} = fifo_mem[rd_ptr];
    assign fifo_level = count;

    assign mem_en = state[1];
    assign mem_we = state[0];

    always_comb begin
        state_nxt = ST_IDLE;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        if (disp_req) begin
            state_nxt = ST_RD;
            addr_nxt  = disp_addr;
        end else if (!fifo_empty) begin
            state_nxt = ST_WR;
            addr_nxt  = head_addr;
            wdata_nxt = head_data;
        end
    end

    // ---- command register (RAM issue stage) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage is pure data; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {wr_addr, wr_data};
    end

    // ---- p1: RAM output stage, read data arrives on mem_rdata ----
    // ---- p2: display return register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1  <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_vld_p1  <= (state == ST_RD);
            disp_valid <= rd_vld_p1;
            if (rd_vld_p1) disp_data <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (disp_req && !fifo_empty) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter with a small behavioural RAM attached to
// the mem_* port. Unwritten RAM words read back as addr + 0x100.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    fifo_level;
    logic [15:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    vram_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .WR_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fifo_level (fifo_level),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port synchronous RAM (low 8 address bits used).
    logic [DW-1:0] ram [256];
    logic [255:0]  written = '0;
    logic [DW-1:0] ram_rdata = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]]     <= mem_wdata;
                written[mem_addr[7:0]] <= 1'b1;
            end else begin
                ram_rdata <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]]
                                                    : DW'(32'(mem_addr[7:0]) + 32'h100);
            end
        end
    end
    assign mem_rdata = ram_rdata;

    function automatic logic [31:0] ram_word(input int a);
        logic [7:0] idx;
        idx = a[7:0];
        return written[idx] ? 32'(ram[idx]) : 32'(idx) + 32'h100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input string tag, input logic [1:0] c, input int a, input int d);
        check({tag, " cmd"}, 32'({mem_en, mem_we}), 32'(c));
        if (c != 2'b00) check({tag, " addr"}, 32'(mem_addr), 32'(a));
        if (c == 2'b11) check({tag, " wdata"}, 32'(mem_wdata), 32'(d));
    endtask

    initial begin
        rst_n     = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // Reset values
        #3;
        check("rst mem_en",     32'(mem_en),     0);
        check("rst mem_we",     32'(mem_we),     0);
        check("rst mem_addr",   32'(mem_addr),   0);
        check("rst mem_wdata",  32'(mem_wdata),  0);
        check("rst disp_valid", 32'(disp_valid), 0);
        check("rst disp_data",  32'(disp_data),  0);
        check("rst fifo_level", 32'(fifo_level), 0);
        check("rst stall_cnt",  32'(stall_cnt),  0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst wr_ready", 32'(wr_ready), 1);

        // 1: four back-to-back reads, latency 3
        for (int i = 0; i < 8; i++) begin
            disp_req  = (i < 4);
            disp_addr = AW'(i);
            check("t1 disp_valid", 32'(disp_valid), 32'((i >= 3 && i <= 6) ? 1 : 0));
            if (i >= 3 && i <= 6) check("t1 disp_data", 32'(disp_data), 32'h100 + 32'(i - 3));
            check("t1 mem_we", 32'(mem_we), 0);
            tick();
        end
        check("t1 valid low", 32'(disp_valid), 0);
        check("t1 data hold", 32'(disp_data), 32'h103);

        // 2: single write drains two cycles after the push edge
        wr_valid = 1'b1;
        wr_addr  = AW'(5);
        wr_data  = DW'(12'hABC);
        check("t2 wr_ready", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        check("t2 level1", 32'(fifo_level), 1);
        cmd("t2 c1", 2'b00, 0, 0);
        tick();
        cmd("t2 c2", 2'b11, 5, 'hABC);
        check("t2 level0", 32'(fifo_level), 0);
        tick();
        cmd("t2 c3", 2'b00, 0, 0);
        check("t2 ram[5]", ram_word(5), 32'hABC);

        // 3: fill under display load, then drain in order
        for (int i = 0; i < 5; i++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(32'h10);
            wr_valid  = 1'b1;
            wr_addr   = AW'(32'h20 + i);
            wr_data   = DW'(32'h300 + i);
            check("t3 wr_ready", 32'(wr_ready), 32'((i < 4) ? 1 : 0));
            check("t3 level", 32'(fifo_level), 32'(i));
            check("t3 no write", 32'(mem_we), 0);
            tick();
        end
        wr_valid = 1'b0;
        disp_req = 1'b0;
        check("t3 stall", 32'(stall_cnt), 4);
        check("t3 level full", 32'(fifo_level), 4);
        check("t3 no write c5", 32'(mem_we), 0);
        tick();
        for (int j = 0; j < 4; j++) begin
            cmd("t3 drain", 2'b11, 32'h20 + j, 32'h300 + j);
            check("t3 drain level", 32'(fifo_level), 32'(3 - j));
            check("t3 disp_valid", 32'(disp_valid), 32'((j < 2) ? 1 : 0));
            if (j < 2) check("t3 disp_data", 32'(disp_data), 32'h110);
            tick();
        end
        cmd("t3 idle", 2'b00, 0, 0);
        check("t3 level end", 32'(fifo_level), 0);
        check("t3 stall end", 32'(stall_cnt), 4);
        for (int j = 0; j < 4; j++) check("t3 ram", ram_word(32'h20 + j), 32'h300 + 32'(j));
        check("t3 rejected word", ram_word(32'h24), 32'h124);

        // 4: push and pop on the same edge at level 2
        disp_req  = 1'b1;
        disp_addr = AW'(32'h11);
        wr_valid  = 1'b1;
        wr_addr   = AW'(32'h30);
        wr_data   = DW'(32'h401);
        tick();
        wr_addr = AW'(32'h31);
        wr_data = DW'(32'h402);
        tick();
        check("t4 level pre", 32'(fifo_level), 2);
        disp_req = 1'b0;
        wr_addr  = AW'(32'h32);
        wr_data  = DW'(32'h403);
        tick();
        wr_valid = 1'b0;
        check("t4 level same", 32'(fifo_level), 2);
        cmd("t4 wr A", 2'b11, 32'h30, 32'h401);
        tick();
        cmd("t4 wr B", 2'b11, 32'h31, 32'h402);
        check("t4 level 1", 32'(fifo_level), 1);
        tick();
        cmd("t4 wr C", 2'b11, 32'h32, 32'h403);
        check("t4 level 0", 32'(fifo_level), 0);
        tick();
        cmd("t4 idle", 2'b00, 0, 0);
        check("t4 stall", 32'(stall_cnt), 5);
        for (int j = 0; j < 3; j++) check("t4 ram", ram_word(32'h30 + j), 32'h401 + 32'(j));

        // 5: alternating display requests with three queued writes
        disp_req  = 1'b1;
        disp_addr = AW'(32'h50);
        wr_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(32'h40 + i);
            wr_data = DW'(32'h501 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("t5 level", 32'(fifo_level), 3);
        disp_req = 1'b0;
        cmd("t5 c3", 2'b10, 32'h50, 0);
        check("t5 c3 valid", 32'(disp_valid), 1);
        check("t5 c3 data", 32'(disp_data), 32'h150);
        tick();
        disp_req  = 1'b1;
        disp_addr = AW'(32'h51);
        cmd("t5 c4", 2'b11, 32'h40, 32'h501);
        check("t5 c4 valid", 32'(disp_valid), 1);
        tick();
        disp_req = 1'b0;
        cmd("t5 c5", 2'b10, 32'h51, 0);
        check("t5 c5 valid", 32'(disp_valid), 1);
        check("t5 c5 data", 32'(disp_data), 32'h150);
        tick();
        disp_req  = 1'b1;
        disp_addr = AW'(32'h52);
        cmd("t5 c6", 2'b11, 32'h41, 32'h502);
        check("t5 c6 valid", 32'(disp_valid), 0);
        tick();
        disp_req = 1'b0;
        cmd("t5 c7", 2'b10, 32'h52, 0);
        check("t5 c7 valid", 32'(disp_valid), 1);
        check("t5 c7 data", 32'(disp_data), 32'h151);
        tick();
        cmd("t5 c8", 2'b11, 32'h42, 32'h503);
        check("t5 c8 valid", 32'(disp_valid), 0);
        tick();
        cmd("t5 c9", 2'b00, 0, 0);
        check("t5 c9 valid", 32'(disp_valid), 1);
        check("t5 c9 data", 32'(disp_data), 32'h152);
        check("t5 level end", 32'(fifo_level), 0);
        check("t5 stall", 32'(stall_cnt), 9);
        for (int j = 0; j < 3; j++) check("t5 ram", ram_word(32'h40 + j), 32'h501 + 32'(j));

        // 6: reset pulse with FIFO at 3 and reads in flight
        disp_req  = 1'b1;
        disp_addr = AW'(32'h60);
        wr_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(32'h70 + i);
            wr_data = DW'(32'h601 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("t6 level pre", 32'(fifo_level), 3);
        check("t6 valid pre", 32'(disp_valid), 1);
        check("t6 data pre", 32'(disp_data), 32'h160);
        check("t6 stall pre", 32'(stall_cnt), 11);
        rst_n    = 1'b0;
        disp_req = 1'b0;
        #1;
        check("t6 mem_en",     32'(mem_en),     0);
        check("t6 mem_we",     32'(mem_we),     0);
        check("t6 mem_addr",   32'(mem_addr),   0);
        check("t6 mem_wdata",  32'(mem_wdata),  0);
        check("t6 disp_valid", 32'(disp_valid), 0);
        check("t6 disp_data",  32'(disp_data),  0);
        check("t6 fifo_level", 32'(fifo_level), 0);
        check("t6 stall_cnt",  32'(stall_cnt),  0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t6 post valid", 32'(disp_valid), 0);
            check("t6 post mem_en", 32'(mem_en), 0);
            check("t6 post level", 32'(fifo_level), 0);
            check("t6 post wr_ready", 32'(wr_ready), 1);
            tick();
        end
        check("t6 ram untouched", ram_word(32'h70), 32'h170);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
